// File: rtl/cmos_capture_crop_pkg.sv
// Shared definitions for the OV5640 capture front end: FSM state codes,
// RGB565 field layout, counter widths and the bring-up colour-bar table.
package cmos_capture_crop_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam int R_LSB = 11;
    localparam int R_W   = 5;
    localparam int G_LSB = 5;
    localparam int G_W   = 6;
    localparam int B_LSB = 0;
    localparam int B_W   = 5;

    localparam int X_W = 12;
    localparam int Y_W = 11;

    // Exchange the red and blue fields, green stays in the middle.
    function automatic logic [15:0] swap_rb(input logic [15:0] p);
        return {p[B_LSB +: B_W], p[G_LSB +: G_W], p[R_LSB +: R_W]};
    endfunction

    // Eight vertical bars: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmos_capture_crop_byte_packer.sv
// cmos_byte_packer: pairs sensor bytes into 16-bit pixels (high byte first),
// optionally swaps R/B, and flags lines that end on a dangling byte.
module cmos_byte_packer #(
    parameter bit SWAP_RB = 1'b1
) (
    input  logic        cmos_pclk,
    input  logic        I_rst_n,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    input  logic        flush,
    input  logic        line_end,
    output logic        pix_vld,
    output logic [15:0] pix_data,
    output logic        odd_end
);
    import cmos_capture_crop_pkg::*;

    logic       phase_q;
    logic [7:0] hi_q;
    logic [15:0] raw;

    // A frame start drops whatever byte arrives with it and restarts pairing.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            phase_q <= 1'b0;
            hi_q    <= 8'd0;
        end else if (flush || !byte_vld) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                hi_q <= byte_in;
            end
        end
    end

    assign raw      = {hi_q, byte_in};
    assign pix_vld  = byte_vld & phase_q & ~flush;
    assign pix_data = SWAP_RB ? swap_rb(raw) : raw;
    assign odd_end  = line_end & phase_q;

endmodule

// File: rtl/cmos_capture_crop.sv
// OV5640 DVP capture: byte packing, start-up frame skip, fixed crop window.
// Define CMOS_CAPTURE_TESTPAT_EN to replace pixel data with 8 colour bars.
module cmos_capture_crop #(
    parameter int SKIP_FRAMES = 10,
    parameter int CROP_X0     = 0,
    parameter int CROP_Y0     = 0,
    parameter int OUT_W       = 1280,
    parameter int OUT_H       = 720,
    parameter bit SWAP_RB     = 1'b1
) (
    input  logic        cmos_pclk,
    input  logic        I_rst_n,
    input  logic        I_cfg_done,
    input  logic        I_cmos_vsync,
    input  logic        I_cmos_href,
    input  logic [7:0]  I_cmos_db,
    output logic        O_vs_n,
    output logic        O_de,
    output logic [15:0] O_data,
    output logic        O_frame_start,
    output logic        O_line_err,
    output logic [1:0]  dbg_state
);
    import cmos_capture_crop_pkg::*;

    localparam int SKW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = (SKIP_FRAMES > 0) ? SKW'(SKIP_FRAMES - 1) : '0;
    localparam logic [X_W:0]   X_LO = (X_W + 1)'(CROP_X0);
    localparam logic [X_W:0]   X_HI = (X_W + 1)'(CROP_X0 + OUT_W);
    localparam logic [Y_W:0]   Y_LO = (Y_W + 1)'(CROP_Y0);
    localparam logic [Y_W:0]   Y_HI = (Y_W + 1)'(CROP_Y0 + OUT_H);
    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

    logic           s1_vsync, s1_href, s1_vsync_d, s1_href_d;
    logic [7:0]     s1_db;
    logic           frame_start, line_end;
    logic [1:0]     state_q, state_d;
    logic [SKW-1:0] skip_cnt, skip_d;
    logic           accept;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           pix_vld, odd_end, in_win, de_next;
    logic [15:0]    pix_data, pix_out;

    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            s1_vsync   <= 1'b0;
            s1_href    <= 1'b0;
            s1_db      <= 8'd0;
            s1_vsync_d <= 1'b0;
            s1_href_d  <= 1'b0;
        end else begin
            s1_vsync   <= I_cmos_vsync;
            s1_href    <= I_cmos_href;
            s1_db      <= I_cmos_db;
            s1_vsync_d <= s1_vsync;
            s1_href_d  <= s1_href;
        end
    end

    assign frame_start = s1_vsync & ~s1_vsync_d;
    assign line_end    = ~s1_href & s1_href_d;

    cmos_byte_packer #(
        .SWAP_RB (SWAP_RB)
    ) u_packer (
        .cmos_pclk (cmos_pclk),
        .I_rst_n   (I_rst_n),
        .byte_vld  (s1_href),
        .byte_in   (s1_db),
        .flush     (frame_start),
        .line_end  (line_end),
        .pix_vld   (pix_vld),
        .pix_data  (pix_data),
        .odd_end   (odd_end)
    );

    // The frame start that leaves IDLE is not counted as a skipped frame;
    // the SKIP_FRAMES-th start seen in SKIP opens the first captured frame.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_cnt;
        if (!I_cfg_done) begin
            state_d = ST_IDLE;
            skip_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    skip_d = '0;
                    if (frame_start) begin
                        state_d = (SKIP_FRAMES == 0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (frame_start) begin
                        if (skip_cnt == SKIP_LAST) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            skip_d = skip_cnt + 1'b1;
                        end
                    end
                end
                ST_CAPTURE: state_d = ST_CAPTURE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q  <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state_q  <= state_d;
            skip_cnt <= skip_d;
        end
    end

    assign accept    = I_cfg_done & frame_start & (state_d == ST_CAPTURE);
    assign dbg_state = state_q;

    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_start) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (line_end) begin
            x_cnt <= '0;
            if (y_cnt != Y_MAX) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end else if (pix_vld && (x_cnt != X_MAX)) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    assign in_win = ({1'b0, x_cnt} >= X_LO) && ({1'b0, x_cnt} < X_HI) &&
                    ({1'b0, y_cnt} >= Y_LO) && ({1'b0, y_cnt} < Y_HI);

    // O_de is a valid-only qualifier: the buffer has no backpressure, so each
    // high cycle is exactly one pixel and O_data is held between pixels.
    assign de_next = pix_vld & in_win & (state_q == ST_CAPTURE) & I_cfg_done;

`ifdef CMOS_CAPTURE_TESTPAT_EN
    assign pix_out = bar_color(x_cnt[10:8]);
`else
    assign pix_out = pix_data;
`endif

    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_vs_n        <= 1'b1;
            O_de          <= 1'b0;
            O_data        <= 16'd0;
            O_frame_start <= 1'b0;
            O_line_err    <= 1'b0;
        end else begin
            O_vs_n        <= ~s1_vsync;
            O_de          <= de_next;
            O_frame_start <= accept;
            if (de_next) begin
                O_data <= pix_out;
            end
            if (odd_end) begin
                O_line_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture_crop.sv
// Bench for cmos_capture_crop: two configurations driven from the same pins,
// checked every cycle against a frame/line/byte-count reference model.
module tb_cmos_capture_crop;
    import cmos_capture_crop_pkg::*;

    logic        cmos_pclk = 1'b0;
    logic        I_rst_n = 1'b1;
    logic        I_cfg_done = 1'b0;
    logic        I_cmos_vsync = 1'b0;
    logic        I_cmos_href = 1'b0;
    logic [7:0]  I_cmos_db = 8'd0;
    logic        a_vs_n, a_de, a_fs, a_err, b_vs_n, b_de, b_fs, b_err;
    logic [15:0] a_data, b_data;
    logic [1:0]  a_state, b_state;

    always #5 cmos_pclk = ~cmos_pclk;

    cmos_capture_crop #(.SKIP_FRAMES(2), .CROP_X0(0), .CROP_Y0(0), .OUT_W(1280), .OUT_H(720),
                        .SWAP_RB(1'b1)) dut_a (
        .cmos_pclk(cmos_pclk), .I_rst_n(I_rst_n), .I_cfg_done(I_cfg_done),
        .I_cmos_vsync(I_cmos_vsync), .I_cmos_href(I_cmos_href), .I_cmos_db(I_cmos_db),
        .O_vs_n(a_vs_n), .O_de(a_de), .O_data(a_data), .O_frame_start(a_fs),
        .O_line_err(a_err), .dbg_state(a_state));

    cmos_capture_crop #(.SKIP_FRAMES(0), .CROP_X0(2), .CROP_Y0(1), .OUT_W(3), .OUT_H(2),
                        .SWAP_RB(1'b0)) dut_b (
        .cmos_pclk(cmos_pclk), .I_rst_n(I_rst_n), .I_cfg_done(I_cfg_done),
        .I_cmos_vsync(I_cmos_vsync), .I_cmos_href(I_cmos_href), .I_cmos_db(I_cmos_db),
        .O_vs_n(b_vs_n), .O_de(b_de), .O_data(b_data), .O_frame_start(b_fs),
        .O_line_err(b_err), .dbg_state(b_state));

    int c_skip[2] = '{2, 0};
    int c_x0[2]   = '{0, 2};
    int c_w[2]    = '{1280, 3};
    int c_y0[2]   = '{0, 1};
    int c_h[2]    = '{720, 2};
    bit c_swap[2] = '{1'b1, 1'b0};

    bit         m_armed[2], m_err[2];
    int         m_starts[2], m_nbytes[2], m_y[2];
    logic [7:0] m_hi[2];
    bit         e_vs_n[2], e_de[2], e_fs[2], e_err[2];
    logic [15:0] e_data[2];
    bit         h_vs1, h_vs2, h_href1, h_href2;
    logic [7:0] h_db1;

    int n_checks = 0;
    int n_err = 0;
    int de_cnt[2], fs_cnt[2];
    logic [15:0] last_data[2];
    bit cfg_want = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_pixel(input int d, input int hi, input int lo, input int x);
`ifdef CMOS_CAPTURE_TESTPAT_EN
        case ((x / 256) % 8)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
`else
        int p, r, g, b;
        p = hi * 256 + lo;
        if (!c_swap[d]) return 16'(p);
        r = p / 2048;
        g = (p / 32) % 64;
        b = p % 32;
        return 16'(b * 2048 + g * 32 + r);
`endif
    endfunction

    // Predicts outputs after the next clock edge from what stage 1 now holds.
    task automatic model_step(input int d);
        bit fs, le, cfg, cap, pix;
        int px;
        fs  = h_vs1 && !h_vs2;
        le  = !h_href1 && h_href2;
        cfg = I_cfg_done;
        cap = m_armed[d] && (m_starts[d] > c_skip[d]);
        pix = 1'b0;
        px  = 0;
        if (le && (m_nbytes[d] % 2 == 1)) m_err[d] = 1'b1;
        if (fs) m_nbytes[d] = 0;
        else if (h_href1) begin
            m_nbytes[d]++;
            if (m_nbytes[d] % 2 == 1) m_hi[d] = h_db1;
            else begin
                pix = 1'b1;
                px = m_nbytes[d] / 2 - 1;
                if (px > 4095) px = 4095;
            end
        end else m_nbytes[d] = 0;
        e_de[d] = pix && cap && cfg && px >= c_x0[d] && px < c_x0[d] + c_w[d] &&
                  m_y[d] >= c_y0[d] && m_y[d] < c_y0[d] + c_h[d];
        if (e_de[d]) e_data[d] = exp_pixel(d, int'(m_hi[d]), int'(h_db1), px);
        if (fs) m_y[d] = 0;
        else if (le && m_y[d] < 2047) m_y[d]++;
        if (!cfg) m_armed[d] = 1'b0;
        else if (fs) begin
            if (!m_armed[d]) begin
                m_armed[d] = 1'b1;
                m_starts[d] = 1;
            end else if (m_starts[d] <= c_skip[d]) m_starts[d]++;
        end
        e_fs[d]   = fs && cfg && m_armed[d] && (m_starts[d] > c_skip[d]);
        e_vs_n[d] = !h_vs1;
        e_err[d]  = m_err[d];
    endtask

    task automatic check_dut(input int d, input string t, input logic vs_n, input logic de,
                             input logic [15:0] data, input logic fs, input logic err);
        chk({t, "_vs_n"}, 32'(vs_n), 32'(e_vs_n[d]));
        chk({t, "_de"}, 32'(de), 32'(e_de[d]));
        chk({t, "_frame_start"}, 32'(fs), 32'(e_fs[d]));
        chk({t, "_line_err"}, 32'(err), 32'(e_err[d]));
        if (e_de[d]) chk({t, "_data"}, 32'(data), 32'(e_data[d]));
        if (de === 1'b1) begin
            de_cnt[d]++;
            last_data[d] = data;
        end
        if (fs === 1'b1) fs_cnt[d]++;
    endtask

    task automatic tick(input bit vs, input bit href, input logic [7:0] db);
        @(negedge cmos_pclk);
        check_dut(0, "a", a_vs_n, a_de, a_data, a_fs, a_err);
        check_dut(1, "b", b_vs_n, b_de, b_data, b_fs, b_err);
        I_cmos_vsync = vs;
        I_cmos_href  = href;
        I_cmos_db    = db;
        I_cfg_done   = cfg_want;
        for (int d = 0; d < 2; d++) model_step(d);
        h_vs2 = h_vs1;
        h_href2 = h_href1;
        h_vs1 = vs;
        h_href1 = href;
        h_db1 = db;
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            de_cnt[d] = 0;
            fs_cnt[d] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge cmos_pclk);
        I_rst_n = 1'b0;
        #1;
        chk("rst_a_vs_n", 32'(a_vs_n), 32'd1);
        chk("rst_a_de", 32'(a_de), 32'd0);
        chk("rst_a_data", 32'(a_data), 32'd0);
        chk("rst_a_frame_start", 32'(a_fs), 32'd0);
        chk("rst_a_line_err", 32'(a_err), 32'd0);
        chk("rst_a_state", 32'(a_state), 32'(ST_IDLE));
        chk("rst_b_de", 32'(b_de), 32'd0);
        chk("rst_b_line_err", 32'(b_err), 32'd0);
        chk("rst_b_state", 32'(b_state), 32'(ST_IDLE));
        I_cmos_vsync = 1'b0;
        I_cmos_href = 1'b0;
        I_cmos_db = 8'd0;
        for (int d = 0; d < 2; d++) begin
            m_armed[d] = 1'b0; m_err[d] = 1'b0; m_starts[d] = 0; m_nbytes[d] = 0;
            m_y[d] = 0; m_hi[d] = 8'd0; e_vs_n[d] = 1'b1; e_de[d] = 1'b0;
            e_fs[d] = 1'b0; e_err[d] = 1'b0; e_data[d] = 16'd0;
        end
        h_vs1 = 0; h_vs2 = 0; h_href1 = 0; h_href2 = 0; h_db1 = 8'd0;
        repeat (2) @(negedge cmos_pclk);
        I_rst_n = 1'b1;
    endtask

    // mode 0: random bytes, 1: pairs 12/34, 2: pairs F8/1F; short_line gets 7 bytes
    task automatic send_frame(input int lines, input int bpl, input int mode, input int short_line);
        logic [7:0] db;
        int n;
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        for (int l = 0; l < lines; l++) begin
            n = (l == short_line) ? 7 : bpl;
            for (int b = 0; b < n; b++) begin
                if (mode == 1) db = (b % 2 == 1) ? 8'h34 : 8'h12;
                else if (mode == 2) db = (b % 2 == 1) ? 8'h1F : 8'hF8;
                else db = 8'($urandom_range(0, 255));
                tick(0, 1, db);
            end
            tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        end
    endtask

    task automatic trailing_vsync();
        tick(1, 0, 0); tick(1, 0, 0);
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    endtask

    task automatic rtick(input bit vs, input bit href, input logic [7:0] db);
        if (cfg_want && $urandom_range(0, 299) == 0) cfg_want = 1'b0;
        else if (!cfg_want && $urandom_range(0, 7) == 0) cfg_want = 1'b1;
        tick(vs, href, db);
    endtask

    initial begin
        do_reset();
        cfg_want = 1'b1;
        repeat (3) tick(0, 0, 0);

        // Skip two frames, capture frames 3-4; trailing vsync closes frame 4.
        clear_counts();
        send_frame(4, 8, 0, -1);
        send_frame(4, 8, 0, -1);
        send_frame(4, 8, 0, -1);
        send_frame(4, 8, 1, -1);
        trailing_vsync();
        chk("skip_a_de_count", 32'(de_cnt[0]), 32'd32);
        chk("skip_a_fs_count", 32'(fs_cnt[0]), 32'd3);
        chk("crop_b_de_count_8px", 32'(de_cnt[1]), 32'd16);
        chk("b_fs_count", 32'(fs_cnt[1]), 32'd5);
`ifndef CMOS_CAPTURE_TESTPAT_EN
        chk("swap_a_data_1234", 32'(last_data[0]), 32'h0000A222);
        chk("noswap_b_data_1234", 32'(last_data[1]), 32'h00001234);
`endif

        // Crop window on 8-pixel lines: x 2..4, y 1..2 -> 6 pixels per frame.
        clear_counts();
        send_frame(4, 16, 2, -1);
        send_frame(4, 16, 2, -1);
        trailing_vsync();
        chk("crop_b_de_count", 32'(de_cnt[1]), 32'd12);
        chk("full_a_de_count", 32'(de_cnt[0]), 32'd64);
`ifndef CMOS_CAPTURE_TESTPAT_EN
        chk("a_data_f81f", 32'(last_data[0]), 32'h0000F81F);
        chk("b_data_f81f", 32'(last_data[1]), 32'h0000F81F);
`endif

        // Odd-length line: 3 pixels from it and a sticky error flag.
        clear_counts();
        send_frame(4, 8, 0, 1);
        chk("odd_a_de_count", 32'(de_cnt[0]), 32'd15);
        chk("odd_b_de_count", 32'(de_cnt[1]), 32'd3);
        chk("odd_a_line_err", 32'(a_err), 32'd1);
        clear_counts();
        send_frame(4, 8, 0, -1);
        trailing_vsync();
        chk("good_a_de_count", 32'(de_cnt[0]), 32'd16);
        chk("sticky_a_line_err", 32'(a_err), 32'd1);
        chk("sticky_b_line_err", 32'(b_err), 32'd1);

        // cfg_done dropped mid-line: nothing until the next vsync (plus skip).
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        for (int b = 0; b < 8; b++) tick(0, 1, 8'($urandom_range(0, 255)));
        tick(0, 0, 0); tick(0, 0, 0);
        for (int b = 0; b < 4; b++) tick(0, 1, 8'($urandom_range(0, 255)));
        cfg_want = 1'b0;
        for (int b = 0; b < 3; b++) tick(0, 1, 8'($urandom_range(0, 255)));
        chk("drop_a_de_low", 32'(a_de), 32'd0);
        cfg_want = 1'b1;
        clear_counts();
        for (int b = 0; b < 5; b++) tick(0, 1, 8'($urandom_range(0, 255)));
        tick(0, 0, 0); tick(0, 0, 0);
        for (int l = 0; l < 2; l++) begin
            for (int b = 0; b < 8; b++) tick(0, 1, 8'($urandom_range(0, 255)));
            tick(0, 0, 0); tick(0, 0, 0);
        end
        chk("redrop_a_de_count", 32'(de_cnt[0]), 32'd0);
        chk("redrop_b_de_count", 32'(de_cnt[1]), 32'd0);
        send_frame(4, 8, 0, -1);
        send_frame(4, 8, 0, -1);
        chk("reskip_a_de_count", 32'(de_cnt[0]), 32'd0);
        send_frame(4, 8, 0, -1);
        chk("recapture_a_de_count", 32'(de_cnt[0]), 32'd16);

        // Randomized traffic: odd lengths, vsync during href, cfg_done glitches.
        for (int f = 0; f < 30; f++) begin
            int nl, vlen, gap, bpl;
            nl = $urandom_range(1, 6);
            vlen = $urandom_range(1, 3);
            gap = $urandom_range(0, 3);
            for (int i = 0; i < vlen; i++) rtick(1, 0, 0);
            for (int i = 0; i < gap; i++) rtick(0, 0, 0);
            for (int l = 0; l < nl; l++) begin
                bpl = $urandom_range(0, 20);
                for (int b = 0; b < bpl; b++)
                    rtick($urandom_range(0, 60) == 0, 1, 8'($urandom_range(0, 255)));
                for (int i = 0; i < $urandom_range(1, 3); i++) rtick(0, 0, 0);
            end
        end

        // Reset asserted mid-capture: outputs clear at once, FSM back in IDLE.
        do_reset();
        cfg_want = 1'b1;
        repeat (3) tick(0, 0, 0);
        send_frame(4, 8, 0, -1);
        send_frame(4, 8, 0, -1);
        clear_counts();
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        for (int b = 0; b < 8; b++) tick(0, 1, 8'($urandom_range(0, 255)));
        chk("pre_reset_a_de_count", 32'(de_cnt[0]), 32'd3);
        chk("pre_reset_a_state", 32'(a_state), 32'(ST_CAPTURE));
        do_reset();
        clear_counts();
        send_frame(4, 8, 0, -1);
        trailing_vsync();
        chk("post_reset_a_de_count", 32'(de_cnt[0]), 32'd0);
        chk("post_reset_b_de_count", 32'(de_cnt[1]), 32'd4);
        chk("post_reset_a_line_err", 32'(a_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
